// File: rtl/tetris_pkg.sv
// Shared board-logic definitions: default board geometry, row-clear FSM
// states and the line-clear score table.
package tetris_pkg;

  localparam int BOARD_W_DEFAULT = 10;
  localparam int BOARD_H_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } clr_state_e;

  localparam logic [19:0] LINE_SCORE [5] = '{20'd0, 20'd40, 20'd100, 20'd300, 20'd1200};

  // Four or more lines in one pass all score as a four-line clear.
  function automatic logic [19:0] line_score(input int unsigned lines);
    logic [19:0] pts;
    case (lines)
      32'd0:   pts = LINE_SCORE[0];
      32'd1:   pts = LINE_SCORE[1];
      32'd2:   pts = LINE_SCORE[2];
      32'd3:   pts = LINE_SCORE[3];
      default: pts = LINE_SCORE[4];
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/board_row_shift.sv
// Combinational row delete: removes row row_i, drops every row above it by
// one and zero-fills the top row. Rows below row_i pass through unchanged.
module board_row_shift
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEFAULT,
  parameter int BOARD_H = BOARD_H_DEFAULT
) (
  input  logic [BOARD_W*BOARD_H-1:0]  board_i,
  input  logic [$clog2(BOARD_H)-1:0]  row_i,
  output logic [BOARD_W*BOARD_H-1:0]  board_o
);

  // Row 0 is always at or above the deleted row, so it always becomes empty.
  always_comb begin
    board_o = board_i;
    board_o[BOARD_W-1:0] = '0;
    for (int r = 1; r < BOARD_H; r++) begin
      if (r <= int'(row_i)) begin
        board_o[r*BOARD_W +: BOARD_W] = board_i[(r-1)*BOARD_W +: BOARD_W];
      end else begin
        board_o[r*BOARD_W +: BOARD_W] = board_i[r*BOARD_W +: BOARD_W];
      end
    end
  end

endmodule

// File: rtl/row_clear_engine.sv
// Full-row clear engine: captures a settled board on start, deletes every
// full row bottom-to-top and reports the compacted board and cleared count.
// Optional line scoring is enabled with `define ROW_CLEAR_SCORE_EN.
module row_clear_engine
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEFAULT,
  parameter int BOARD_H = BOARD_H_DEFAULT,
  parameter int CNT_W   = $clog2(BOARD_H + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pause,
  input  logic [BOARD_W*BOARD_H-1:0]   board_in,
  output logic [BOARD_W*BOARD_H-1:0]   board_out,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             rows_cleared,
  output logic [$clog2(BOARD_H)-1:0]   cur_row
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [19:0]                  score
`endif
);

  localparam int NB = BOARD_W * BOARD_H;
  localparam int RW = $clog2(BOARD_H);
  localparam logic [RW-1:0]    ROW_LAST = RW'(BOARD_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BOARD_H);

  clr_state_e        state_q, state_d;
  logic [NB-1:0]     board_q, board_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic [RW-1:0]     row_q, row_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [NB-1:0]     shifted_board;
  logic              row_full;
  logic              next_full;

  board_row_shift #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_shift (
    .board_i (board_q),
    .row_i   (row_q),
    .board_o (shifted_board)
  );

  // next_full tests the row that drops into cur_row, so a shift also re-tests.
  assign row_full  = &board_q[int'(row_q)*BOARD_W +: BOARD_W];
  assign next_full = &shifted_board[int'(row_q)*BOARD_W +: BOARD_W];

  // Next-state and datapath update; pause holds every register.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    rows_d  = rows_q;
    row_d   = row_q;
    done_d  = done_q;
    busy_d  = busy_q;
    if (!pause) begin
      done_d = (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            board_d = board_in;
            rows_d  = '0;
            row_d   = ROW_LAST;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            state_d = ST_SHIFT;
          end else if (row_q == '0) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q - RW'(1'b1);
            state_d = ST_SCAN;
          end
        end
        ST_SHIFT: begin
          board_d = shifted_board;
          if (rows_q != CNT_MAX) begin
            rows_d = rows_q + CNT_W'(1'b1);
          end else begin
            rows_d = rows_q;
          end
          if (next_full) begin
            state_d = ST_SHIFT;
          end else if (row_q == '0) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q - RW'(1'b1);
            state_d = ST_SCAN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      busy_d = (state_d != ST_IDLE);
    end else begin
      done_d = done_q;
      busy_d = busy_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      board_q <= '0;
      rows_q  <= '0;
      row_q   <= ROW_LAST;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      rows_q  <= rows_d;
      row_q   <= row_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign board_out    = board_q;
  assign rows_cleared = rows_q;
  assign cur_row      = row_q;
  assign done         = done_q;
  assign busy         = busy_q;

`ifdef ROW_CLEAR_SCORE_EN
  logic [19:0] score_q, score_d;
  logic [20:0] score_sum;

  // Score accumulates in the DONE cycle, saturating at the 20-bit maximum.
  always_comb begin
    score_sum = {1'b0, score_q} + {1'b0, line_score(32'(rows_q))};
    if (!pause && (state_q == ST_DONE)) begin
      score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end else begin
      score_d = score_q;
    end
  end

  // Score register; start does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 20'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine with hand-computed expectations.
// Score checks are included when ROW_CLEAR_SCORE_EN is defined.
module tb_row_clear_engine;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int NB = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic [NB-1:0] board_in;
  logic [NB-1:0] board_out;
  logic          busy;
  logic          done;
  logic [4:0]    rows_cleared;
  logic [4:0]    cur_row;
`ifdef ROW_CLEAR_SCORE_EN
  logic [19:0]   score;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edges;
  int done_seen;
  logic [NB-1:0] b;
  logic [NB-1:0] exp_b;

  row_clear_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .board_in     (board_in),
    .board_out    (board_out),
    .busy         (busy),
    .done         (done),
    .rows_cleared (rows_cleared),
    .cur_row      (cur_row)
`ifdef ROW_CLEAR_SCORE_EN
    ,
    .score        (score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] put_row(input logic [NB-1:0] brd, input int r, input logic [W-1:0] v);
    logic [NB-1:0] t;
    t = brd;
    t[r*W +: W] = v;
    return t;
  endfunction

  // Starts one pass and counts edges after the start edge until done is seen.
  task automatic run_pass(input logic [NB-1:0] brd, output int n);
    board_in = brd;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; board_in = '0;
    tick(); tick();
    check_eq("rst_board", board_out, NB'(0));
    check_eq("rst_rows", NB'(rows_cleared), NB'(0));
    check_eq("rst_cur_row", NB'(cur_row), NB'(19));
    check_eq("rst_done", NB'(done), NB'(0));
    check_eq("rst_busy", NB'(busy), NB'(0));
`ifdef ROW_CLEAR_SCORE_EN
    check_eq("rst_score", NB'(score), NB'(0));
`endif
    rst = 1'b0;
    tick();

    // Rows 19,18 full, row 17 = 1: two clears, bottom row ends as 1.
    b = '0;
    b = put_row(b, 19, 10'h3FF);
    b = put_row(b, 18, 10'h3FF);
    b = put_row(b, 17, 10'h001);
    run_pass(b, edges);
    check_eq("A_latency", NB'(edges), NB'(23));
    check_eq("A_rows", NB'(rows_cleared), NB'(2));
    exp_b = put_row('0, 19, 10'h001);
    check_eq("A_board", board_out, exp_b);
    check_eq("A_busy_at_done", NB'(busy), NB'(0));
    pause = 1'b1;
    tick();
    check_eq("A_pause_holds_done", NB'(done), NB'(1));
    pause = 1'b0;
    tick();
    check_eq("A_done_drops", NB'(done), NB'(0));
    check_eq("A_rows_hold", NB'(rows_cleared), NB'(2));

    // Non-adjacent full rows 19 and 15.
    b = '0;
    b = put_row(b, 19, 10'h3FF);
    b = put_row(b, 18, 10'h003);
    b = put_row(b, 17, 10'h0F0);
    b = put_row(b, 16, 10'h155);
    b = put_row(b, 15, 10'h3FF);
    run_pass(b, edges);
    check_eq("B_latency", NB'(edges), NB'(23));
    check_eq("B_rows", NB'(rows_cleared), NB'(2));
    exp_b = '0;
    exp_b = put_row(exp_b, 19, 10'h003);
    exp_b = put_row(exp_b, 18, 10'h0F0);
    exp_b = put_row(exp_b, 17, 10'h155);
    check_eq("B_board", board_out, exp_b);
    tick();

    // Every cell set.
    run_pass({NB{1'b1}}, edges);
    check_eq("C_latency", NB'(edges), NB'(41));
    check_eq("C_rows", NB'(rows_cleared), NB'(20));
    check_eq("C_board", board_out, NB'(0));
    tick();

    // Board A again, paused for 5 edges mid-pass, plus a start while busy.
    b = '0;
    b = put_row(b, 19, 10'h3FF);
    b = put_row(b, 18, 10'h3FF);
    b = put_row(b, 17, 10'h001);
    board_in = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (edges == 4) pause = 1'b1;
      if (edges == 9) begin
        check_eq("D_cur_row_frozen", NB'(cur_row), NB'(17));
        check_eq("D_rows_frozen", NB'(rows_cleared), NB'(2));
        pause = 1'b0;
      end
      if (edges == 12) begin
        check_eq("D_busy_mid", NB'(busy), NB'(1));
        board_in = '1;
        start = 1'b1;
      end
      if (edges == 13) start = 1'b0;
    end
    check_eq("D_latency", NB'(edges), NB'(28));
    check_eq("D_rows", NB'(rows_cleared), NB'(2));
    check_eq("D_board", board_out, put_row('0, 19, 10'h001));
    tick(); tick(); tick();
    check_eq("D_no_requeue_busy", NB'(busy), NB'(0));
    check_eq("D_no_requeue_board", board_out, put_row('0, 19, 10'h001));

    // Reset while the engine sits in SHIFT.
    board_in = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("E_board", board_out, NB'(0));
    check_eq("E_rows", NB'(rows_cleared), NB'(0));
    check_eq("E_done", NB'(done), NB'(0));
    check_eq("E_busy", NB'(busy), NB'(0));
    check_eq("E_cur_row", NB'(cur_row), NB'(19));
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check_eq("E_no_done", NB'(done_seen), NB'(0));

`ifdef ROW_CLEAR_SCORE_EN
    b = '0;
    b = put_row(b, 19, 10'h3FF);
    b = put_row(b, 18, 10'h3FF);
    b = put_row(b, 17, 10'h3FF);
    b = put_row(b, 16, 10'h3FF);
    run_pass(b, edges);
    check_eq("F_rows4", NB'(rows_cleared), NB'(4));
    check_eq("F_score4", NB'(score), NB'(1200));
    tick();
    run_pass(put_row('0, 19, 10'h3FF), edges);
    check_eq("F_rows1", NB'(rows_cleared), NB'(1));
    check_eq("F_score1", NB'(score), NB'(1240));
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
